// File: rtl/armleocpu_regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package armleocpu_regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int unsigned WP_LOAD  = 0;
    localparam int unsigned WP_ALU   = 1;
    localparam int unsigned WR_PORTS = 2;

    // Address maps to a physical entry: nonzero and below the register count.
    function automatic logic addr_ok(input int unsigned addr, input int unsigned count);
        return (addr != 0) && (addr < count);
    endfunction

endpackage

// File: rtl/armleocpu_regfile_clearseq.sv
// Clear sequencer: walks entries 1..REG_COUNT-1 writing zero after reset or on request.
module armleocpu_regfile_clearseq
    import armleocpu_regfile_pkg::*;
#(
    parameter  int unsigned REG_COUNT = 32,
    localparam int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == ADDR_W'(REG_COUNT - 1)) begin
                    state_d = READY;
                    cnt_d   = ADDR_W'(1);
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = ADDR_W'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = ADDR_W'(1);
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/armleocpu_regfile_mp.sv
// Parametrised register file: N registered read ports with write-first bypass,
// two prioritised write ports (ALU over load), and a zeroing clear sequencer.
module armleocpu_regfile_mp
    import armleocpu_regfile_pkg::*;
#(
    parameter  int unsigned XLEN       = 32,
    parameter  int unsigned REG_COUNT  = 32,
    parameter  int unsigned READ_PORTS = 2,
    localparam int unsigned ADDR_W     = $clog2(REG_COUNT)
) (
    input  logic                                  clk,
    input  logic                                  async_rst_n,
    input  logic [READ_PORTS-1:0]                 rs_read,
    input  logic [READ_PORTS-1:0][ADDR_W-1:0]     rs_addr,
    output logic [READ_PORTS-1:0][XLEN-1:0]       rs_rdata,
    input  logic [WR_PORTS-1:0]                   rd_write,
    input  logic [WR_PORTS-1:0][ADDR_W-1:0]       rd_addr,
    input  logic [WR_PORTS-1:0][XLEN-1:0]         rd_wdata,
    input  logic                                  clear_req,
    output logic                                  busy
);

    logic [XLEN-1:0]                   mem [1:REG_COUNT-1];
    logic                              clr_we;
    logic [ADDR_W-1:0]                 clr_addr;
    logic [WR_PORTS-1:0]               wr_ok;
    logic [READ_PORTS-1:0][XLEN-1:0]   rd_val;

    armleocpu_regfile_clearseq #(
        .REG_COUNT (REG_COUNT)
    ) u_clearseq (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .clear_req   (clear_req),
        .busy        (busy),
        .clr_we      (clr_we),
        .clr_addr    (clr_addr)
    );

    // Effective write enables: dropped while clearing and for x0 / out-of-range.
    always_comb begin
        wr_ok = '0;
        for (int unsigned i = 0; i < WR_PORTS; i++) begin
            wr_ok[i] = rd_write[i] && !busy && addr_ok(32'(rd_addr[i]), REG_COUNT);
        end
    end

    // Later port in the loop wins, so WP_ALU overrides WP_LOAD on a collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int unsigned i = 0; i < WR_PORTS; i++) begin
                if (wr_ok[i]) begin
                    mem[rd_addr[i]] <= rd_wdata[i];
                end
            end
        end
    end

    // Array lookup with write-first bypass; same ALU-over-load priority as the array.
    always_comb begin
        rd_val = '0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            if (addr_ok(32'(rs_addr[p]), REG_COUNT)) begin
                rd_val[p] = mem[rs_addr[p]];
                for (int unsigned i = 0; i < WR_PORTS; i++) begin
                    if (wr_ok[i] && (rd_addr[i] == rs_addr[p])) begin
                        rd_val[p] = rd_wdata[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rs_rdata <= '0;
        end else if (busy) begin
            rs_rdata <= '0;
        end else begin
            for (int unsigned p = 0; p < READ_PORTS; p++) begin
                if (rs_read[p]) begin
                    rs_rdata[p] <= rd_val[p];
                end
            end
        end
    end

endmodule

// File: doc/armleocpu_regfile_mp.md
# armleocpu_regfile_mp

Parametrised multi-port integer register file, the successor of the fixed 32×32, 2-read/1-write register file. It has configurable width, depth and read-port count, and two prioritised write ports. Reads are registered with write-first bypass. A clear sequencer zeroes the array after reset or on request. It sits between decode (read addresses) and the writeback stages (ALU and load writeback) of the CPU pipeline.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- REG_COUNT, 32, number of registers; must be ≥2; entry 0 is hardwired zero.
- READ_PORTS, 2, number of read ports (1..4).
- ADDR_W, $clog2(REG_COUNT), address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- async_rst_n  in  1  reset, asynchronous, active-low.
- rs_read  in  READ_PORTS  per-port read enable.
- rs_addr  in  READ_PORTS×ADDR_W  per-port read address.
- rs_rdata  out  READ_PORTS×XLEN  per-port registered read data.
- rd_write  in  2  per-write-port enable; port 1 is ALU writeback, port 0 is load writeback.
- rd_addr  in  2×ADDR_W  write addresses.
- rd_wdata  in  2×XLEN  write data.
- clear_req  in  1  request to re-zero the whole array.
- busy  out  1  high while the clear sequence runs.

## Operation
- Storage: REG_COUNT-1 physical entries (indices 1..REG_COUNT-1). The array itself has no reset.
- Write: on a clock edge with rd_write[i]=1 and busy=0, entry rd_addr[i] ← rd_wdata[i].
  - Writes to address 0 are ignored.
  - Writes to addresses ≥REG_COUNT are ignored.
  - Both ports to the same address: port 1 wins.
- Read: on a clock edge with rs_read[p]=1 and busy=0, rs_rdata[p] ← value at rs_addr[p].
  - Address 0 or address ≥REG_COUNT returns 0.
  - rs_read[p]=0: rs_rdata[p] holds its previous value.
- Bypass (write-first): a read and an enabled write to the same nonzero in-range address in the same cycle return that cycle's write data. When both write ports match, port 1's data is returned.
- Clear FSM states: CLEAR, READY.
  - Reset enters CLEAR with cnt=1.
  - CLEAR: each cycle writes 0 to entry cnt, then cnt++. When cnt=REG_COUNT-1 is written, the next state is READY.
  - READY → CLEAR (cnt=1) on clear_req=1.
  - clear_req is ignored in CLEAR.
- While busy=1: rd_write and rs_read are ignored, and rs_rdata is driven to 0 on every edge.
- busy=1 exactly when the state is CLEAR.

## Timing
- Reset values: rs_rdata=0 for all ports, busy=1, state=CLEAR, cnt=1.
- Post-reset clear: REG_COUNT-1 cycles. For REG_COUNT=32, busy falls after the 31st rising edge following reset deassertion.
- clear_req sampled high in READY: busy rises on the next edge. The array is zero after REG_COUNT-1 further edges.
- Read latency: 1 cycle. Address is presented in cycle N; data is valid after edge N and stays stable until the next enabled read.
- Write visible to a non-bypassed read issued the following cycle.
- Reset asserted mid-clear or mid-operation: outputs return to reset values immediately and asynchronously, and the clear sequence restarts from cnt=1.
- Simultaneous clear_req and writes in READY: the writes that cycle are performed, then the clear overwrites them.

## Structure
- Shared package armleocpu_regfile_pkg holds:
  - state enum (CLEAR, READY);
  - write-port index constants WP_LOAD=0 and WP_ALU=1.
- One sub-module, armleocpu_regfile_clearseq, contains the FSM and counter. It outputs busy, clr_we and clr_addr.
- The top level holds the array, the write priority mux, the bypass compare and the read registers.

## Test plan
- Reset, hold all inputs at 0: busy=1 for 31 cycles then 0, rs_rdata=0 throughout, all 31 entries read back 0.
- Write 0xFF00FF00 to x1 via port 1; next cycle read x1 on ports 0 and 1 → both 0xFF00FF00. Write 0xDEADBEEF to x0 → reading x0 returns 0.
- Same-cycle writes: x5 via port 0 = 0x11111111 and port 1 = 0x22222222 → x5 reads 0x22222222. Same-cycle read of x5 → 0x22222222 (bypass).
- rs_read=0 after reading 0x12345678: change rs_addr and write a new value → rs_rdata stays 0x12345678.
- Fill x1..x31 with their index values, then pulse clear_req: busy=1 for 31 cycles, and writes attempted during busy are dropped. Afterwards all entries read 0.
- REG_COUNT=24, READ_PORTS=3, XLEN=64: read x30 → 0, write x30 ignored. Assert reset at cnt=10 → busy stays 1, and the clear completes 23 cycles after release.
